a2d_intf: RTL and testbench



---
 rtl/a2d_intf.sv | 163 ++++++++++++++++
 tb/tb_a2d_intf.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_intf.sv
// a2d_intf: SPI initiator for an ADC128S-style 12-bit converter.
// One conversion request runs two identical 16-bit frames. The first frame
// selects the channel and the second frame returns that channel's result.
// SCLK is clk/32 and idles high. MISO is sampled on each SCLK rise and
// shifted in on the following fall. The first fall of each frame is a
// front-porch edge, so 16 shifts complete at the point the 17th fall would occur.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | SS_n high, SCLK high; waiting for strt_cnv
// FRAME | SS_n low; SCLK toggling, MOSI shifted out / MISO shifted in
// GAP   | SS_n high for 32 clk between the channel-select and result frames
// DONE  | latch result from shreg, pulse cnv_cmplt, return to IDLE

module a2d_intf (
   input  logic        clk,
   input  logic        rst,
   input  logic        strt_cnv,
   input  logic [2:0]  chnnl,
   output logic        cnv_cmplt,
   output logic [11:0] res,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // sclk_div starts 8 clk short of a fall so the first fall lands after the front porch
   localparam logic [4:0] SCLK_START    = 5'b11000;
   localparam logic [4:0] SCLK_TOP      = 5'b11111;
   localparam logic [4:0] SCLK_PRE_RISE = 5'b01111;
   localparam logic [4:0] GAP_LOAD      = 5'd31;
   // fall 0 is the porch edge; falls 1..15 shift; fall 16 is the final shift
   localparam logic [4:0] FALL_LAST     = 5'd16;

   state_t      state;
   state_t      state_nxt;

   logic [4:0]  sclk_div;
   logic [15:0] shreg;
   logic        miso_ff;
   logic        frame;
   logic [4:0]  gap_cnt;
   logic [4:0]  fall_cnt;
   logic [2:0]  chnnl_q;

   logic        sclk_fall;
   logic        sclk_rise;
   logic        last_shift;
   logic        load_frame;
   logic [2:0]  cmd_ch;
   logic [15:0] cmd_word;

   assign SCLK = sclk_div[4];
   assign MOSI = shreg[15];

   assign sclk_fall  = (state == FRAME) && (sclk_div == SCLK_TOP);
   assign sclk_rise  = (state == FRAME) && (sclk_div == SCLK_PRE_RISE);
   assign last_shift = sclk_fall && (fall_cnt == FALL_LAST);

   // The channel is taken live on acceptance, then from the captured copy for frame 2
   assign cmd_ch   = (state == IDLE) ? chnnl : chnnl_q;
   assign cmd_word = {2'b00, cmd_ch, 11'h000};

   // Next-state decode and frame-load strobe
   always_comb begin
      state_nxt  = state;
      load_frame = 1'b0;
      case (state)
         IDLE: begin
            if (strt_cnv) begin
               load_frame = 1'b1;
               state_nxt  = FRAME;
            end
         end
         FRAME: begin
            if (last_shift) begin
               state_nxt = frame ? DONE : GAP;
            end
         end
         GAP: begin
            if (gap_cnt == 5'd0) begin
               load_frame = 1'b1;
               state_nxt  = FRAME;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // SPI datapath: SCLK divider, shift register, chip select and result
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_div  <= SCLK_TOP;
         shreg     <= 16'h0000;
         miso_ff   <= 1'b0;
         frame     <= 1'b0;
         gap_cnt   <= 5'd0;
         fall_cnt  <= 5'd0;
         chnnl_q   <= 3'd0;
         SS_n      <= 1'b1;
         res       <= 12'h000;
         cnv_cmplt <= 1'b0;
      end else begin
         cnv_cmplt <= 1'b0;
         if (load_frame) begin
            shreg    <= cmd_word;
            sclk_div <= SCLK_START;
            fall_cnt <= 5'd0;
            SS_n     <= 1'b0;
            frame    <= (state == GAP);
            if (state == IDLE) begin
               chnnl_q <= chnnl;
            end
         end else if (state == FRAME) begin
            if (last_shift) begin
               // Hold sclk_div at the top so SCLK stays high while SS_n rises
               shreg   <= {shreg[14:0], miso_ff};
               SS_n    <= 1'b1;
               gap_cnt <= GAP_LOAD;
            end else begin
               sclk_div <= sclk_div + 5'd1;
               if (sclk_rise) begin
                  miso_ff <= MISO;
               end
               if (sclk_fall) begin
                  fall_cnt <= fall_cnt + 5'd1;
                  if (fall_cnt != 5'd0) begin
                     shreg <= {shreg[14:0], miso_ff};
                  end
               end
            end
         end else if (state == GAP) begin
            gap_cnt <= gap_cnt - 5'd1;
         end else if (state == DONE) begin
            res       <= shreg[11:0];
            cnv_cmplt <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_a2d_intf.sv
// Testbench for a2d_intf with a behavioural ADC128S model.
// The ADC returns data for the channel selected by the previous frame,
// MSB-first, with four leading zeros.
`timescale 1ns/1ps

module tb_a2d_intf;

   logic        clk = 1'b0;
   logic        rst;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   a2d_intf dut (
      .clk       (clk),
      .rst       (rst),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   always #5 clk = ~clk;

   // ---------------- ADC model ----------------
   logic [11:0] adc_data [8];
   logic [2:0]  sel_ch     = 3'd0;
   int          nrise      = 0;
   int          rise_total = 0;
   int          ss_falls   = 0;
   int          n_pulses   = 0;
   logic [15:0] mosi_word  = 16'h0000;
   logic [15:0] cmd_q [$];

   function automatic logic bit_for(input int r);
      logic [11:0] d;
      logic [3:0]  idx;
      d = adc_data[sel_ch];
      if (r >= 5 && r <= 16) begin
         idx = 4'(16 - r);
         return d[idx];
      end
      return 1'b0;
   endfunction

   // Count SCLK rises, capture the command, close a frame on SS_n rising
   always @(posedge SCLK or posedge SS_n) begin
      if (SS_n !== 1'b0) begin
         if (nrise == 16) begin
            cmd_q.push_back(mosi_word);
            sel_ch = mosi_word[13:11];
         end
         nrise = 0;
      end else begin
         nrise      = nrise + 1;
         rise_total = rise_total + 1;
         mosi_word  = {mosi_word[14:0], MOSI};
      end
   end

   // Drive MISO for the next rise on frame start and on every SCLK fall
   always @(negedge SS_n or negedge SCLK) begin
      if (SS_n === 1'b0) begin
         if (SCLK === 1'b1) ss_falls = ss_falls + 1;
         MISO = bit_for(nrise + 1);
      end
   end

   always @(negedge clk) begin
      if (cnv_cmplt === 1'b1) n_pulses = n_pulses + 1;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns just after the accepting edge (k = 0); chnnl is scrambled afterwards
   task automatic start_conv(input logic [2:0] ch);
      strt_cnv = 1'b1;
      chnnl    = ch;
      tick();
      strt_cnv = 1'b0;
      chnnl    = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_cmplt(input int limit, output int k);
      k = 0;
      while (cnv_cmplt !== 1'b1 && k < limit) begin
         tick();
         k++;
      end
   endtask

   function automatic logic [15:0] cmd_of(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      int errs;
      rst = 1'b1;
      strt_cnv = 1'b0;
      chnnl = 3'd0;
      repeat (5) tick();
      n_checks++; if (SS_n !== 1'b1) $display("FAIL reset_ss_n got %b want 1", SS_n); else n_pass++;
      n_checks++; if (SCLK !== 1'b1) $display("FAIL reset_sclk got %b want 1", SCLK); else n_pass++;
      n_checks++; if (MOSI !== 1'b0) $display("FAIL reset_mosi got %b want 0", MOSI); else n_pass++;
      n_checks++; if (cnv_cmplt !== 1'b0) $display("FAIL reset_cmplt got %b want 0", cnv_cmplt); else n_pass++;
      n_checks++; if (res !== 12'h000) $display("FAIL reset_res got %h want 000", res); else n_pass++;
      rst = 1'b0;
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (SCLK !== 1'b1 || SS_n !== 1'b1) errs++;
      end
      n_checks++; if (errs != 0) $display("FAIL idle_lines got %0d bad cycles want 0", errs); else n_pass++;
   endtask

   task automatic test_single();
      int ss_err, sclk_err, cc_err, first_bad, q0, p0, j;
      logic exp_ss, exp_sclk, exp_cc;
      logic [11:0] res_at;
      adc_data[4] = 12'hA5C;
      q0 = cmd_q.size();
      p0 = n_pulses;
      ss_err = 0; sclk_err = 0; cc_err = 0; first_bad = -1;
      res_at = 12'h000;
      start_conv(3'd4);
      for (int k = 0; k <= 1080; k++) begin
         exp_ss = !((k <= 519) || (k >= 552 && k <= 1071));
         j = (k <= 519) ? k : k - 552;
         exp_sclk = 1'b1;
         if (!exp_ss && j >= 8 && ((j - 8) % 32) < 16) exp_sclk = 1'b0;
         exp_cc = (k == 1073);
         if (SS_n !== exp_ss) begin ss_err++; if (first_bad < 0) first_bad = k; end
         if (SCLK !== exp_sclk) begin sclk_err++; if (first_bad < 0) first_bad = k; end
         if (cnv_cmplt !== exp_cc) begin cc_err++; if (first_bad < 0) first_bad = k; end
         if (k == 1073) res_at = res;
         tick();
      end
      n_checks++; if (ss_err != 0) $display("FAIL single_ss_n_timing got %0d bad cycles (first %0d) want 0", ss_err, first_bad); else n_pass++;
      n_checks++; if (sclk_err != 0) $display("FAIL single_sclk_timing got %0d bad cycles (first %0d) want 0", sclk_err, first_bad); else n_pass++;
      n_checks++; if (cc_err != 0) $display("FAIL single_cmplt_timing got %0d bad cycles (first %0d) want 0", cc_err, first_bad); else n_pass++;
      n_checks++; if (res_at !== 12'hA5C) $display("FAIL single_res got %h want a5c", res_at); else n_pass++;
      n_checks++; if (n_pulses - p0 != 1) $display("FAIL single_pulses got %0d want 1", n_pulses - p0); else n_pass++;
      n_checks++; if (cmd_q.size() - q0 != 2) $display("FAIL single_frames got %0d want 2", cmd_q.size() - q0);
      else begin
         n_pass++;
         n_checks++;
         if (cmd_q[q0] !== 16'h2000 || cmd_q[q0 + 1] !== 16'h2000)
            $display("FAIL single_mosi got %h %h want 2000 2000", cmd_q[q0], cmd_q[q0 + 1]);
         else n_pass++;
      end
   endtask

   task automatic conv_and_check(input string nm, input logic [2:0] ch);
      int k, f0, r0, q0;
      f0 = ss_falls; r0 = rise_total; q0 = cmd_q.size();
      start_conv(ch);
      wait_cmplt(1200, k);
      n_checks++; if (k != 1073) $display("FAIL %s_latency ch%0d got %0d want 1073", nm, ch, k); else n_pass++;
      n_checks++; if (res !== adc_data[ch]) $display("FAIL %s_res ch%0d got %h want %h", nm, ch, res, adc_data[ch]); else n_pass++;
      n_checks++; if (ss_falls - f0 != 2 || rise_total - r0 != 32)
         $display("FAIL %s_edges ch%0d got %0d falls %0d rises want 2 32", nm, ch, ss_falls - f0, rise_total - r0);
      else n_pass++;
      n_checks++;
      if (cmd_q.size() - q0 != 2 || cmd_q[q0] !== cmd_of(ch) || cmd_q[q0 + 1] !== cmd_of(ch))
         $display("FAIL %s_cmd ch%0d got %0d frames want 2 of %h", nm, ch, cmd_q.size() - q0, cmd_of(ch));
      else n_pass++;
      tick();
   endtask

   task automatic test_channel_sweep();
      for (int ch = 0; ch < 8; ch++) adc_data[ch] = 12'(12'h111 * (ch + 1));
      for (int ch = 0; ch < 8; ch++) conv_and_check("sweep", 3'(ch));
   endtask

   task automatic test_random();
      logic [2:0] ch;
      for (int n = 0; n < 6; n++) begin
         ch = 3'($urandom_range(0, 7));
         adc_data[ch] = 12'($urandom);
         repeat ($urandom_range(0, 20)) tick();
         conv_and_check("random", ch);
      end
   endtask

   task automatic test_busy();
      logic [2:0] a, b;
      int k, p0, f0, q0;
      for (int ch = 0; ch < 8; ch++) adc_data[ch] = 12'(12'h111 * (ch + 1));
      a = 3'($urandom_range(0, 7));
      b = a ^ 3'd5;
      p0 = n_pulses; f0 = ss_falls; q0 = cmd_q.size();
      start_conv(a);
      repeat (99) tick();
      strt_cnv = 1'b1; chnnl = b; tick(); strt_cnv = 1'b0;
      repeat (499) tick();
      strt_cnv = 1'b1; chnnl = b; tick(); strt_cnv = 1'b0;
      wait_cmplt(1200, k);
      n_checks++; if (res !== adc_data[a]) $display("FAIL busy_res got %h want %h", res, adc_data[a]); else n_pass++;
      repeat (1200) tick();
      n_checks++; if (n_pulses - p0 != 1) $display("FAIL busy_pulses got %0d want 1", n_pulses - p0); else n_pass++;
      n_checks++; if (ss_falls - f0 != 2) $display("FAIL busy_frames got %0d want 2", ss_falls - f0); else n_pass++;
      n_checks++;
      if (cmd_q.size() - q0 != 2 || cmd_q[q0] !== cmd_of(a) || cmd_q[q0 + 1] !== cmd_of(a))
         $display("FAIL busy_cmd got %0d frames want 2 of %h", cmd_q.size() - q0, cmd_of(a));
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [2:0] a, b;
      int k, held_err;
      a = 3'($urandom_range(0, 7));
      b = a + 3'd3;
      adc_data[a] = 12'($urandom);
      adc_data[b] = ~adc_data[a];
      start_conv(a);
      wait_cmplt(1200, k);
      n_checks++; if (res !== adc_data[a]) $display("FAIL b2b_first_res got %h want %h", res, adc_data[a]); else n_pass++;
      strt_cnv = 1'b1; chnnl = b;
      tick();
      strt_cnv = 1'b0;
      n_checks++; if (SS_n !== 1'b0) $display("FAIL b2b_ss_n_fall got %b want 0", SS_n); else n_pass++;
      held_err = 0;
      k = 0;
      while (cnv_cmplt !== 1'b1 && k < 1200) begin
         if (res !== adc_data[a]) held_err++;
         tick();
         k++;
      end
      n_checks++; if (held_err != 0) $display("FAIL b2b_res_held got %0d bad cycles want 0", held_err); else n_pass++;
      n_checks++; if (k != 1073) $display("FAIL b2b_latency got %0d want 1073", k); else n_pass++;
      n_checks++; if (res !== adc_data[b]) $display("FAIL b2b_second_res got %h want %h", res, adc_data[b]); else n_pass++;
      tick();
   endtask

   task automatic test_mid_reset();
      int p0;
      logic [2:0] ch;
      ch = 3'($urandom_range(0, 7));
      start_conv(ch);
      repeat (299) tick();
      rst = 1'b1;
      tick();
      n_checks++; if (SS_n !== 1'b1) $display("FAIL midrst_ss_n got %b want 1", SS_n); else n_pass++;
      n_checks++; if (SCLK !== 1'b1) $display("FAIL midrst_sclk got %b want 1", SCLK); else n_pass++;
      n_checks++; if (res !== 12'h000) $display("FAIL midrst_res got %h want 000", res); else n_pass++;
      rst = 1'b0;
      p0 = n_pulses;
      repeat (1200) tick();
      n_checks++; if (n_pulses != p0) $display("FAIL midrst_no_pulse got %0d want 0", n_pulses - p0); else n_pass++;
      adc_data[ch] = 12'($urandom);
      conv_and_check("after_rst", ch);
   endtask

   initial begin
      for (int ch = 0; ch < 8; ch++) adc_data[ch] = 12'h000;
      test_reset();
      test_single();
      test_channel_sweep();
      test_random();
      test_busy();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
